// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_pkg
// Brief  : Shared types and constants for the fetch/data memory arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [3:0]  BE_FULL         = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_watchdog.sv
//------------------------------------------------------------------------------
// Module : arb_watchdog
// Brief  : Counts unacknowledged BUSY cycles; flags expiry at TIMEOUT (0 = off).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_watchdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expire_o = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
            assign expire_o = (cnt_q == LIMIT);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one single-ported memory between fetch
//          and load/store paths, one registered transaction at a time.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q,  last_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic        if_done_q,   if_done_d;
    logic        if_err_q,    if_err_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        d_done_q,    d_done_d;
    logic        d_err_q,     d_err_d;
    logic [31:0] d_rdata_q,   d_rdata_d;

    logic        w_if_elig;
    logic        w_d_elig;
    logic        w_grant;
    owner_e      w_pick;
    logic        w_expire;
    logic        w_wd_enable;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;

    // A port is not re-granted in the cycle its own completion pulse is visible.
    assign w_if_elig = if_req & ~if_done_q;
    assign w_d_elig  = d_req  & ~d_done_q;
    assign w_grant   = (state_q == IDLE) & (w_if_elig | w_d_elig);
    assign w_pick    = (w_if_elig && w_d_elig) ? ((last_q == OWN_IF) ? OWN_D : OWN_IF)
                                               : (w_d_elig ? OWN_D : OWN_IF);
    assign w_wd_enable = (state_q == BUSY) & ~mem_ack;

    arb_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (w_grant),
        .enable_i (w_wd_enable),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        w_rsp_err   = 1'b0;
        w_rsp_data  = '0;

        case (state_q)
            IDLE: begin
                if (w_grant) begin
                    state_d   = BUSY;
                    owner_d   = w_pick;
                    mem_req_d = 1'b1;
                    if (w_pick == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = word_align(d_addr);
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = word_align(if_addr);
                        mem_wdata_d = '0;
                        mem_be_d    = BE_FULL;
                    end
                end
            end
            BUSY: begin
                // An acknowledge in the expiry cycle still counts as success.
                if (mem_ack || w_expire) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    last_d     = owner_q;
                    w_rsp_err  = ~mem_ack;
                    w_rsp_data = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                    if (owner_q == OWN_IF) begin
                        if_done_d  = 1'b1;
                        if_err_d   = w_rsp_err;
                        if_rdata_d = w_rsp_data;
                    end else begin
                        d_done_d   = 1'b1;
                        d_err_d    = w_rsp_err;
                        d_rdata_d  = w_rsp_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter (default and TIMEOUT=4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        if_done, if_err, d_done, d_err, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        t_if_done, t_if_err, t_d_done, t_d_err, t_mem_req, t_mem_we;
    logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk (clk), .reset (reset),
        .if_req (if_req), .if_addr (if_addr),
        .if_done (if_done), .if_rdata (if_rdata), .if_err (if_err),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_be (d_be),
        .d_done (d_done), .d_rdata (d_rdata), .d_err (d_err),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_be (mem_be),
        .mem_ack (mem_ack), .mem_rdata (mem_rdata)
    );

    mem_arbiter #(.TIMEOUT (4), .CNT_W (8)) u_dut_to (
        .clk (clk), .reset (reset),
        .if_req (if_req), .if_addr (if_addr),
        .if_done (t_if_done), .if_rdata (t_if_rdata), .if_err (t_if_err),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_be (d_be),
        .d_done (t_d_done), .d_rdata (t_d_rdata), .d_err (t_d_err),
        .mem_req (t_mem_req), .mem_we (t_mem_we), .mem_addr (t_mem_addr),
        .mem_wdata (t_mem_wdata), .mem_be (t_mem_be),
        .mem_ack (mem_ack), .mem_rdata (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        do_reset();
        check_eq("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_addr",  mem_addr, 32'd0);
        check_eq("rst_mem_be",    {28'd0, mem_be}, 32'd0);
        check_eq("rst_dones",     {30'd0, if_done, d_done}, 32'd0);
        check_eq("rst_rdata",     if_rdata | d_rdata, 32'd0);

        // Single fetch, zero wait states
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        check_eq("fetch_mem_req",  {31'd0, mem_req}, 32'd1);
        check_eq("fetch_mem_addr", mem_addr, 32'h0000_0010);
        check_eq("fetch_mem_we",   {31'd0, mem_we}, 32'd0);
        check_eq("fetch_mem_be",   {28'd0, mem_be}, 32'hF);
        mem_ack = 1'b1; mem_rdata = 32'h0051_0093;
        tick();
        check_eq("fetch_done",  {31'd0, if_done}, 32'd1);
        check_eq("fetch_rdata", if_rdata, 32'h0051_0093);
        check_eq("fetch_err",   {31'd0, if_err}, 32'd0);
        check_eq("fetch_mem_req_drop", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        check_eq("fetch_done_pulse", {31'd0, if_done}, 32'd0);

        // Store with unaligned address and partial byte enables
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0103; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        tick();
        check_eq("st_mem_addr",  mem_addr, 32'h0000_0100);
        check_eq("st_mem_be",    {28'd0, mem_be}, 32'h3);
        check_eq("st_mem_we",    {31'd0, mem_we}, 32'd1);
        check_eq("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check_eq("st_done",  {31'd0, d_done}, 32'd1);
        check_eq("st_rdata", d_rdata, 32'd0);
        check_eq("st_err",   {31'd0, d_err}, 32'd0);
        idle_inputs();
        tick();

        // Tie after reset: fetch, data, fetch
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0044;
        tick();
        check_eq("tie1_addr", mem_addr, 32'h0000_0020);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        check_eq("tie1_if_done", {31'd0, if_done}, 32'd1);
        check_eq("tie1_rdata",   if_rdata, 32'h1111_1111);
        mem_ack = 1'b0;
        tick();
        check_eq("tie2_mem_req", {31'd0, mem_req}, 32'd1);
        check_eq("tie2_addr",    mem_addr, 32'h0000_0044);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        check_eq("tie2_d_done", {31'd0, d_done}, 32'd1);
        check_eq("tie2_rdata",  d_rdata, 32'h2222_2222);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        check_eq("tie3_mem_req", {31'd0, mem_req}, 32'd1);
        check_eq("tie3_addr",    mem_addr, 32'h0000_0020);
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        check_eq("tie3_if_done", {31'd0, if_done}, 32'd1);
        idle_inputs();
        tick();

        // Watchdog expiry on the TIMEOUT=4 instance; d_rdata was nonzero before
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
        tick();
        check_eq("to_mem_req", {31'd0, t_mem_req}, 32'd1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check_eq("to_wait_done", {31'd0, t_d_done}, 32'd0);
            check_eq("to_wait_req",  {31'd0, t_mem_req}, 32'd1);
        end
        tick();
        check_eq("to_done",  {31'd0, t_d_done}, 32'd1);
        check_eq("to_err",   {31'd0, t_d_err}, 32'd1);
        check_eq("to_rdata", t_d_rdata, 32'd0);
        check_eq("to_req_off", {31'd0, t_mem_req}, 32'd0);
        d_req = 1'b0;
        tick();
        check_eq("to_after_req", {31'd0, t_mem_req}, 32'd0);
        check_eq("to_after_done", {31'd0, t_d_done}, 32'd0);

        // Acknowledge arriving in the expiry cycle wins
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0084;
        tick();
        for (int j = 1; j <= 4; j++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h55AA_1234;
        tick();
        check_eq("toack_done",  {31'd0, t_d_done}, 32'd1);
        check_eq("toack_err",   {31'd0, t_d_err}, 32'd0);
        check_eq("toack_rdata", t_d_rdata, 32'h55AA_1234);
        idle_inputs();
        tick();

        // Wait states on the default instance
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0031;
        tick();
        for (int j = 0; j < 5; j++) begin
            check_eq("ws_mem_req",  {31'd0, mem_req}, 32'd1);
            check_eq("ws_mem_addr", mem_addr, 32'h0000_0030);
            check_eq("ws_done",     {31'd0, if_done}, 32'd0);
            tick();
        end
        check_eq("ws_req_at_ack", {31'd0, mem_req}, 32'd1);
        check_eq("ws_done_at_ack", {31'd0, if_done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        check_eq("ws_done_after", {31'd0, if_done}, 32'd1);
        check_eq("ws_rdata",      if_rdata, 32'h0BAD_F00D);
        check_eq("ws_err",        {31'd0, if_err}, 32'd0);
        idle_inputs();
        tick();

        // Reset mid-BUSY; last owner is fetch before the reset
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0090; d_wdata = 32'hA5A5_A5A5; d_be = 4'hF;
        tick();
        check_eq("rb_busy_addr", mem_addr, 32'h0000_0090);
        tick();
        reset = 1'b1; d_req = 1'b0;
        tick();
        check_eq("rb_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rb_no_done", {31'd0, d_done}, 32'd0);
        check_eq("rb_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0040; d_req = 1'b1;
        tick();
        check_eq("rb_tie_no_done", {31'd0, d_done}, 32'd0);
        check_eq("rb_tie_addr", mem_addr, 32'h0000_0040);
        check_eq("rb_tie_we",   {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_0001;
        tick();
        check_eq("rb_tie_if_done", {31'd0, if_done}, 32'd1);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
